// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 FFT butterfly datapath.
// Complex samples are packed as {re, im}: bits 31:16 real, 15:0 imaginary, signed Q1.15.
package fft_pkg;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } cplx16_t;

    localparam logic signed [15:0] Q15_MAX  = 16'sh7FFF;
    localparam logic signed [15:0] Q15_MIN  = 16'sh8000;
    localparam logic signed [31:0] PROD_RND = 32'sd16384;

    // One butterfly component: a +/- m, then either halved with round-half-up
    // or saturated to Q1.15. Bit 16 of the result flags a saturation.
    function automatic logic [16:0] bfly_comp(
        input logic signed [15:0] a,
        input logic signed [15:0] m,
        input logic               sub,
        input logic               scale
    );
        logic signed [17:0] s;
        logic signed [17:0] r;
        logic [16:0]        res;
        s = sub ? ($signed({{2{a[15]}}, a}) - $signed({{2{m[15]}}, m}))
                : ($signed({{2{a[15]}}, a}) + $signed({{2{m[15]}}, m}));
        r = (s + 18'sd1) >>> 1;
        if (scale) begin
            res = {1'b0, r[15:0]};
        end else if (s > 18'sd32767) begin
            res = {1'b1, Q15_MAX};
        end else if (s < -18'sd32768) begin
            res = {1'b1, Q15_MIN};
        end else begin
            res = {1'b0, s[15:0]};
        end
        return res;
    endfunction

endpackage

// File: rtl/complexmultiplier.sv
// Full-precision complex multiply of two packed Q1.15 values.
// Output p = {re[63:32], im[31:0]}, each Q2.30; the sums cannot overflow 32 bits.
module complexmultiplier (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] p
);
    logic signed [15:0] ar, ai, br, bi;
    logic signed [31:0] rr, ii, ri, ir;

    assign ar = a[31:16];
    assign ai = a[15:0];
    assign br = b[31:16];
    assign bi = b[15:0];

    assign rr = 32'(ar) * 32'(br);
    assign ii = 32'(ai) * 32'(bi);
    assign ri = 32'(ar) * 32'(bi);
    assign ir = 32'(ai) * 32'(br);

    assign p = {rr - ii, ri + ir};
endmodule

// File: rtl/cplx_round_sat.sv
// Rounds a Q2.30 complex product back to Q1.15 (round half up) with saturation.
module cplx_round_sat
    import fft_pkg::*;
(
    input  logic [63:0] prod,
    output cplx16_t     res,
    output logic        ovf
);
    logic [16:0] re_rs, im_rs;

    function automatic logic [16:0] rnd_sat(input logic [31:0] p);
        logic signed [32:0] t;
        logic [16:0]        r;
        t = $signed({p[31], p}) + $signed({PROD_RND[31], PROD_RND});
        t = t >>> 15;
        if (t > 33'sd32767) begin
            r = {1'b1, Q15_MAX};
        end else if (t < -33'sd32768) begin
            r = {1'b1, Q15_MIN};
        end else begin
            r = {1'b0, t[15:0]};
        end
        return r;
    endfunction

    // Round each part independently; either saturating flags overflow.
    always_comb begin
        re_rs  = rnd_sat(prod[63:32]);
        im_rs  = rnd_sat(prod[31:0]);
        res.re = re_rs[15:0];
        res.im = im_rs[15:0];
        ovf    = re_rs[16] | im_rs[16];
    end
endmodule

// File: rtl/fft_butterfly_stage.sv
// Three-stage radix-2 DIT butterfly: S1 captures inputs, S2 holds the rounded
// W*B product, S3 holds X = A + W*B and Y = A - W*B. All stages share one enable,
// so a stalled output freezes the whole pipe (bubbles are kept).
module fft_butterfly_stage
    import fft_pkg::*;
#(
    parameter int TAG_W = 10,
    parameter int SCALE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [31:0]      in_w,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_x,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag,
    input  logic             ovf_clear,
    output logic             ovf_sticky
);
    logic             en;
    logic             s1_valid, s2_valid;
    cplx16_t          s1_a, s1_b, s1_w, s2_a, s2_m, m_res;
    logic [TAG_W-1:0] s1_tag, s2_tag;
    logic [63:0]      prod;
    logic             m_ovf;
    logic [16:0]      xr, xi, yr, yi;
    logic             bf_ovf;

    assign en       = out_ready | ~out_valid;
    assign in_ready = en;

    complexmultiplier u_mult (
        .a (s1_b),
        .b (s1_w),
        .p (prod)
    );

    cplx_round_sat u_round (
        .prod (prod),
        .res  (m_res),
        .ovf  (m_ovf)
    );

    // S1: capture the incoming pair, twiddle and tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_w     <= '0;
            s1_tag   <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= in_a;
                s1_b   <= in_b;
                s1_w   <= in_w;
                s1_tag <= in_tag;
            end
        end
    end

    // S2: register the rounded product with A and tag delayed alongside.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_m     <= '0;
            s2_tag   <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a   <= s1_a;
                s2_m   <= m_res;
                s2_tag <= s1_tag;
            end
        end
    end

    // Butterfly sum/difference per component from the S2 contents.
    always_comb begin
        xr     = bfly_comp(s2_a.re, s2_m.re, 1'b0, SCALE != 0);
        xi     = bfly_comp(s2_a.im, s2_m.im, 1'b0, SCALE != 0);
        yr     = bfly_comp(s2_a.re, s2_m.re, 1'b1, SCALE != 0);
        yi     = bfly_comp(s2_a.im, s2_m.im, 1'b1, SCALE != 0);
        bf_ovf = xr[16] | xi[16] | yr[16] | yi[16];
    end

    // S3: output register; data only reloads for valid beats so bubbles leave it untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_tag   <= '0;
        end else if (en) begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_x   <= {xr[15:0], xi[15:0]};
                out_y   <= {yr[15:0], yi[15:0]};
                out_tag <= s2_tag;
            end
        end
    end

    // Sticky overflow: only advancing valid beats count, and a new set beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (en && ((s1_valid && m_ovf) || (s2_valid && bf_ovf))) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clear) begin
            ovf_sticky <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fft_butterfly_stage.sv
// Bench for the butterfly stage: table vectors, random streams with backpressure,
// and reset while pairs are in flight. Expected results queue up at accept time.
module tb_fft_butterfly_stage;
    localparam int TAG_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a, in_b, in_w;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_x, out_y;
    logic [TAG_W-1:0] out_tag;
    logic             ovf_clear;
    logic             ovf_sticky;

    always #5 clk = ~clk;

    fft_butterfly_stage #(.TAG_W(TAG_W), .SCALE(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_w       (in_w),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_tag    (out_tag),
        .ovf_clear  (ovf_clear),
        .ovf_sticky (ovf_sticky)
    );

    typedef struct {
        logic [31:0]      x;
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        int               acc_cyc;
        bit               lat;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] w;
        logic [31:0] x;
        logic [31:0] y;
        bit          ovf;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_out = 0;
    bit          drv_use_table = 0;
    logic [31:0] drv_x, drv_y;
    bit          lat_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic int prod_q15(input longint p, output bit o);
        longint r;
        r = (p + 64'sd16384) >>> 15;
        o = 0;
        if (r > 32767) begin
            r = 32767;
            o = 1;
        end else if (r < -32768) begin
            r = -32768;
            o = 1;
        end
        return int'(r);
    endfunction

    // Reference butterfly with 1/2 scaling, computed in plain integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                                  output logic [31:0] x, output logic [31:0] y);
        int     ar, ai, br, bi, wr, wi, mr, mi, xr, xi, yr, yi;
        longint pr, pi;
        bit     o1, o2;
        ar = int'($signed(a[31:16])); ai = int'($signed(a[15:0]));
        br = int'($signed(b[31:16])); bi = int'($signed(b[15:0]));
        wr = int'($signed(w[31:16])); wi = int'($signed(w[15:0]));
        pr = longint'(br) * wr - longint'(bi) * wi;
        pi = longint'(br) * wi + longint'(bi) * wr;
        mr = prod_q15(pr, o1);
        mi = prod_q15(pi, o2);
        xr = (ar + mr + 1) >>> 1;
        xi = (ai + mi + 1) >>> 1;
        yr = (ar - mr + 1) >>> 1;
        yi = (ai - mi + 1) >>> 1;
        x = {16'(xr), 16'(xi)};
        y = {16'(yr), 16'(yi)};
    endfunction

    // Monitor/scoreboard, sampling on the falling edge.
    initial begin
        bit               prev_stall;
        logic [31:0]      px, py;
        logic [TAG_W-1:0] pt;
        exp_t             e;
        prev_stall = 0;
        px = '0; py = '0; pt = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb.delete();
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", 32'(out_valid), 32'd1);
                    chk("hold_x", out_x, px);
                    chk("hold_y", out_y, py);
                    chk("hold_tag", 32'(out_tag), 32'(pt));
                end
                if (out_valid && !out_ready) chk("stall_in_ready", 32'(in_ready), 32'd0);
                if (in_valid && in_ready) begin
                    e.tag = in_tag;
                    e.acc_cyc = cyc;
                    e.lat = lat_mode;
                    if (drv_use_table) begin
                        e.x = drv_x;
                        e.y = drv_y;
                    end else begin
                        model(in_a, in_b, in_w, e.x, e.y);
                    end
                    sb.push_back(e);
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output actual_tag=%0d required=none", out_tag);
                    end else begin
                        e = sb.pop_front();
                        chk("out_x", out_x, e.x);
                        chk("out_y", out_y, e.y);
                        chk("out_tag", 32'(out_tag), 32'(e.tag));
                        if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd3);
                    end
                end
                prev_stall = out_valid && !out_ready;
                px = out_x;
                py = out_y;
                pt = out_tag;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                        input int tag, input bit use_tab, input logic [31:0] x, input logic [31:0] y);
        int n;
        bit acc;
        n = 0;
        in_valid = 1'b1;
        in_a = a; in_b = b; in_w = w;
        in_tag = TAG_W'(tag);
        drv_use_table = use_tab;
        drv_x = x; drv_y = y;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted tag=%0d", tag);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual_pending=%0d required=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic pulse_clear();
        ovf_clear = 1'b1;
        tick();
        ovf_clear = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", 32'(ovf_sticky), 32'd0);
        tick();
    endtask

    vec_t vt[4];

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
        in_a = '0; in_b = '0; in_w = '0; in_tag = '0;
        drv_x = '0; drv_y = '0;

        vt[0] = '{a: 32'h1000_0000, b: 32'h0800_0000, w: 32'h7FFF_0000,
                  x: 32'h0C00_0000, y: 32'h0400_0000, ovf: 1'b0};
        vt[1] = '{a: 32'h1000_0000, b: 32'h0800_0000, w: 32'h0000_8000,
                  x: 32'h0800_FC00, y: 32'h0800_0400, ovf: 1'b0};
        vt[2] = '{a: 32'h0000_0000, b: 32'h8000_0000, w: 32'h8000_0000,
                  x: 32'h4000_0000, y: 32'hC001_0000, ovf: 1'b1};
        vt[3] = '{a: 32'h7FFF_8000, b: 32'h0000_0000, w: 32'h1234_5678,
                  x: 32'h4000_C000, y: 32'h4000_C000, ovf: 1'b0};

        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_x", out_x, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_ovf", 32'(ovf_sticky), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        tick();

        // Table vectors, one at a time with latency checked.
        lat_mode = 1;
        for (int i = 0; i < 4; i++) begin
            send(vt[i].a, vt[i].b, vt[i].w, 100 + i, 1'b1, vt[i].x, vt[i].y);
            wait_empty(20);
            @(negedge clk);
            chk($sformatf("tab%0d_ovf", i), 32'(ovf_sticky), 32'(vt[i].ovf));
            tick();
            pulse_clear();
        end

        // Backpressure: 8 pairs, out_ready low for cycles 4-8 of the stream.
        lat_mode = 0;
        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send($urandom, $urandom, $urandom, i, 1'b0, '0, '0);
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    out_ready = !(c >= 4 && c <= 8);
                    tick();
                end
                out_ready = 1'b1;
            end
        join
        wait_empty(40);
        chk("stall_count", 32'(n_out - base), 32'd8);

        // Back-to-back 16 pairs with no backpressure.
        lat_mode = 1;
        out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 16; i++)
            send($urandom, $urandom, $urandom, 16 + i, 1'b0, '0, '0);
        wait_empty(20);
        chk("b2b_count", 32'(n_out - base), 32'd16);

        // Reset with three pairs in flight.
        for (int i = 0; i < 3; i++)
            send($urandom, $urandom, $urandom, 40 + i, 1'b0, '0, '0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_x", out_x, 32'd0);
        chk("midrst_out_y", out_y, 32'd0);
        chk("midrst_out_tag", 32'(out_tag), 32'd0);
        tick();
        base = n_out;
        send(vt[0].a, vt[0].b, vt[0].w, 77, 1'b1, vt[0].x, vt[0].y);
        wait_empty(20);
        repeat (4) tick();
        chk("midrst_count", 32'(n_out - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
